// File: rtl/spmv_row_dispatcher_if.sv
// ---------------------------------------------------------------------------
// spmv_row_dispatcher_if
// Stream bundle around the SpMV row dispatcher.
//   S_AXIS_PTR_* : CSR row-pointer stream in (tlast = end pointer of a matrix)
//   S_AXIS_VAL_* : matrix nonzero values in
//   S_AXIS_VEC_* : gathered x[col] values in
//   M_AXIS_A_*   : A operand out (nonzero value)
//   M_AXIS_B_*   : B operand out (vector value)
//   M_AXIS_TIMES_*: per-row operand count out
// Modports:
//   master : the dispatcher itself (producer of the operand stream)
//   slave  : the surrounding environment feeding/draining the dispatcher
// ---------------------------------------------------------------------------
interface spmv_row_dispatcher_if #(
    parameter int PTR_W  = 32,
    parameter int DATA_W = 64
);
    logic [PTR_W-1:0]  S_AXIS_PTR_tdata;
    logic              S_AXIS_PTR_tvalid;
    logic              S_AXIS_PTR_tready;
    logic              S_AXIS_PTR_tlast;

    logic [DATA_W-1:0] S_AXIS_VAL_tdata;
    logic              S_AXIS_VAL_tvalid;
    logic              S_AXIS_VAL_tready;

    logic [DATA_W-1:0] S_AXIS_VEC_tdata;
    logic              S_AXIS_VEC_tvalid;
    logic              S_AXIS_VEC_tready;

    logic [DATA_W-1:0] M_AXIS_A_tdata;
    logic              M_AXIS_A_tvalid;
    logic              M_AXIS_A_tready;

    logic [DATA_W-1:0] M_AXIS_B_tdata;
    logic              M_AXIS_B_tvalid;
    logic              M_AXIS_B_tready;

    logic [PTR_W-1:0]  M_AXIS_TIMES_tdata;
    logic              M_AXIS_TIMES_tvalid;
    logic              M_AXIS_TIMES_tready;

    modport master (
        input  S_AXIS_PTR_tdata, S_AXIS_PTR_tvalid, S_AXIS_PTR_tlast,
        output S_AXIS_PTR_tready,
        input  S_AXIS_VAL_tdata, S_AXIS_VAL_tvalid,
        output S_AXIS_VAL_tready,
        input  S_AXIS_VEC_tdata, S_AXIS_VEC_tvalid,
        output S_AXIS_VEC_tready,
        output M_AXIS_A_tdata, M_AXIS_A_tvalid,
        input  M_AXIS_A_tready,
        output M_AXIS_B_tdata, M_AXIS_B_tvalid,
        input  M_AXIS_B_tready,
        output M_AXIS_TIMES_tdata, M_AXIS_TIMES_tvalid,
        input  M_AXIS_TIMES_tready
    );

    modport slave (
        output S_AXIS_PTR_tdata, S_AXIS_PTR_tvalid, S_AXIS_PTR_tlast,
        input  S_AXIS_PTR_tready,
        output S_AXIS_VAL_tdata, S_AXIS_VAL_tvalid,
        input  S_AXIS_VAL_tready,
        output S_AXIS_VEC_tdata, S_AXIS_VEC_tvalid,
        input  S_AXIS_VEC_tready,
        input  M_AXIS_A_tdata, M_AXIS_A_tvalid,
        output M_AXIS_A_tready,
        input  M_AXIS_B_tdata, M_AXIS_B_tvalid,
        output M_AXIS_B_tready,
        input  M_AXIS_TIMES_tdata, M_AXIS_TIMES_tvalid,
        output M_AXIS_TIMES_tready
    );
endinterface

// File: rtl/spmv_row_dispatcher.sv
// ---------------------------------------------------------------------------
// spmv_row_dispatcher
// Turns a CSR row-pointer stream plus nonzero-value and gathered-vector
// streams into, per row, one TIMES word followed by exactly TIMES lock-stepped
// A/B operand pairs. Empty rows are padded with one (0,0) pair when
// PAD_EMPTY != 0 so every row produces exactly one downstream result.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : stream bundle (master view), see spmv_row_dispatcher_if
//   rows_done : count of TIMES handshakes, wraps modulo 2^32
//   busy      : FSM not idle or any output valid asserted
//   err_ptr   : sticky, a pointer smaller than its predecessor was seen
// ---------------------------------------------------------------------------
module spmv_row_dispatcher #(
    parameter int PTR_W     = 32,
    parameter int DATA_W    = 64,
    parameter int PAD_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    spmv_row_dispatcher_if.master bus,
    output logic [31:0]           rows_done,
    output logic                  busy,
    output logic                  err_ptr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PTR,
        ST_TIMES,
        ST_STREAM,
        ST_PAD
    } state_t;

    state_t              r_state;
    logic                r_ptr_ready;
    logic [PTR_W-1:0]    r_base;
    logic [PTR_W-1:0]    r_len;
    logic [PTR_W-1:0]    r_rem;
    logic                r_last_row;
    logic [PTR_W-1:0]    r_times_data;
    logic                r_times_valid;
    logic [DATA_W-1:0]   r_a_data;
    logic [DATA_W-1:0]   r_b_data;
    logic                r_a_pend;
    logic                r_b_pend;
    logic [31:0]         r_rows_done;
    logic                r_err;

    logic                w_ptr_hs;
    logic                w_times_hs;
    logic                w_slot_free;
    logic                w_take;
    logic                w_decr;
    logic [PTR_W-1:0]    w_len;
    state_t              w_exit_state;

    always_comb begin
        w_ptr_hs     = r_ptr_ready & bus.S_AXIS_PTR_tvalid;
        w_times_hs   = r_times_valid & bus.M_AXIS_TIMES_tready;
        // Slot is free when each half is empty or leaving this cycle.
        w_slot_free  = (~r_a_pend | bus.M_AXIS_A_tready) &
                       (~r_b_pend | bus.M_AXIS_B_tready);
        // VAL and VEC are only ever taken together.
        w_take       = (r_state == ST_STREAM) & (r_rem != '0) & w_slot_free &
                       bus.S_AXIS_VAL_tvalid & bus.S_AXIS_VEC_tvalid;
        w_decr       = bus.S_AXIS_PTR_tdata < r_base;
        w_len        = w_decr ? '0 : (bus.S_AXIS_PTR_tdata - r_base);
        w_exit_state = r_last_row ? ST_IDLE : ST_WAIT_PTR;
    end

    assign bus.S_AXIS_PTR_tready   = r_ptr_ready;
    assign bus.S_AXIS_VAL_tready   = w_take;
    assign bus.S_AXIS_VEC_tready   = w_take;
    assign bus.M_AXIS_A_tdata      = r_a_data;
    assign bus.M_AXIS_A_tvalid     = r_a_pend;
    assign bus.M_AXIS_B_tdata      = r_b_data;
    assign bus.M_AXIS_B_tvalid     = r_b_pend;
    assign bus.M_AXIS_TIMES_tdata  = r_times_data;
    assign bus.M_AXIS_TIMES_tvalid = r_times_valid;
    assign rows_done               = r_rows_done;
    assign err_ptr                 = r_err;
    assign busy                    = (r_state != ST_IDLE) | r_times_valid |
                                     r_a_pend | r_b_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr_ready   <= 1'b0;
            r_base        <= '0;
            r_len         <= '0;
            r_rem         <= '0;
            r_last_row    <= 1'b0;
            r_times_data  <= '0;
            r_times_valid <= 1'b0;
            r_a_data      <= '0;
            r_b_data      <= '0;
            r_a_pend      <= 1'b0;
            r_b_pend      <= 1'b0;
            r_rows_done   <= '0;
            r_err         <= 1'b0;
        end else begin
            // Each pending flag retires on its own handshake; a new load
            // below overrides both.
            if (bus.M_AXIS_A_tready) r_a_pend <= 1'b0;
            if (bus.M_AXIS_B_tready) r_b_pend <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_ptr_ready <= 1'b1;
                    if (w_ptr_hs) begin
                        r_base <= bus.S_AXIS_PTR_tdata;
                        // A lone tlast pointer is a zero-row matrix.
                        if (!bus.S_AXIS_PTR_tlast) r_state <= ST_WAIT_PTR;
                    end
                end
                ST_WAIT_PTR: begin
                    r_ptr_ready <= 1'b1;
                    if (w_ptr_hs) begin
                        r_base        <= bus.S_AXIS_PTR_tdata;
                        r_len         <= w_len;
                        r_times_data  <= (w_len == '0 && PAD_EMPTY != 0) ?
                                         PTR_W'(1) : w_len;
                        r_times_valid <= 1'b1;
                        r_last_row    <= bus.S_AXIS_PTR_tlast;
                        r_ptr_ready   <= 1'b0;
                        r_state       <= ST_TIMES;
                        if (w_decr) r_err <= 1'b1;
                    end
                end
                ST_TIMES: begin
                    if (w_times_hs) begin
                        r_times_valid <= 1'b0;
                        r_rows_done   <= r_rows_done + 32'd1;
                        r_rem         <= r_len;
                        if (r_len != '0) begin
                            r_state <= ST_STREAM;
                        end else if (PAD_EMPTY != 0) begin
                            // r_rem doubles as the "pad pair still owed" flag.
                            r_rem   <= PTR_W'(1);
                            r_state <= ST_PAD;
                        end else begin
                            r_ptr_ready <= 1'b1;
                            r_state     <= w_exit_state;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_take) begin
                        r_a_data <= bus.S_AXIS_VAL_tdata;
                        r_b_data <= bus.S_AXIS_VEC_tdata;
                        r_a_pend <= 1'b1;
                        r_b_pend <= 1'b1;
                        r_rem    <= r_rem - PTR_W'(1);
                    end else if (r_rem == '0 && w_slot_free) begin
                        r_ptr_ready <= 1'b1;
                        r_state     <= w_exit_state;
                    end
                end
                ST_PAD: begin
                    if (w_slot_free) begin
                        if (r_rem != '0) begin
                            r_a_data <= '0;
                            r_b_data <= '0;
                            r_a_pend <= 1'b1;
                            r_b_pend <= 1'b1;
                            r_rem    <= '0;
                        end else begin
                            r_ptr_ready <= 1'b1;
                            r_state     <= w_exit_state;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_row_dispatcher.sv
module tb_spmv_row_dispatcher;
    localparam int PTR_W  = 32;
    localparam int DATA_W = 64;

    typedef struct {
        logic [31:0] p;
        bit          last;
    } ptr_t;

    typedef struct {
        logic [31:0] p0, p1, p2;
        logic [31:0] t1, t2;
        int unsigned pairs;
        bit          err;
    } tvec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spmv_row_dispatcher_if #(.PTR_W(PTR_W), .DATA_W(DATA_W)) bus ();
    spmv_row_dispatcher_if #(.PTR_W(PTR_W), .DATA_W(DATA_W)) bus0 ();

    logic [31:0] rows_done, rows_done0;
    logic        busy, busy0, err_ptr, err_ptr0;

    spmv_row_dispatcher #(.PTR_W(PTR_W), .DATA_W(DATA_W), .PAD_EMPTY(1)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rows_done(rows_done), .busy(busy), .err_ptr(err_ptr)
    );

    spmv_row_dispatcher #(.PTR_W(PTR_W), .DATA_W(DATA_W), .PAD_EMPTY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .rows_done(rows_done0), .busy(busy0), .err_ptr(err_ptr0)
    );

    int n_pass = 0;
    int n_total = 0;

    ptr_t        ptr_q[$];
    logic [63:0] val_q[$], vec_q[$];
    logic [31:0] times_got[$], exp_times[$];
    logic [63:0] a_got[$], b_got[$], exp_a[$], exp_b[$];
    bit          exp_err;
    int          a_cyc[$];

    bit   rnd_in, rnd_out;
    logic t_rdy, a_rdy, b_rdy;
    int   cyc, val_acc, stab_err, align_err;

    bit          hv_t, hv_a, hv_b;
    logic [31:0] hd_t;
    logic [63:0] hd_a, hd_b;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    function automatic void push_ptr(input logic [31:0] p, input bit last);
        ptr_t e;
        e.p = p;
        e.last = last;
        ptr_q.push_back(e);
    endfunction

    // One clock cycle: drive at the falling edge, sample shortly before the
    // rising edge where handshakes take effect.
    task automatic step();
        bus.S_AXIS_PTR_tvalid = (ptr_q.size() != 0) && (!rnd_in || $urandom_range(3, 0) != 0);
        bus.S_AXIS_PTR_tdata  = (ptr_q.size() != 0) ? ptr_q[0].p : '0;
        bus.S_AXIS_PTR_tlast  = (ptr_q.size() != 0) ? ptr_q[0].last : 1'b0;
        bus.S_AXIS_VAL_tvalid = (val_q.size() != 0) && (!rnd_in || $urandom_range(3, 0) != 0);
        bus.S_AXIS_VAL_tdata  = (val_q.size() != 0) ? val_q[0] : '0;
        bus.S_AXIS_VEC_tvalid = (vec_q.size() != 0) && (!rnd_in || $urandom_range(3, 0) != 0);
        bus.S_AXIS_VEC_tdata  = (vec_q.size() != 0) ? vec_q[0] : '0;
        bus.M_AXIS_TIMES_tready = rnd_out ? ($urandom_range(3, 0) != 0) : t_rdy;
        bus.M_AXIS_A_tready     = rnd_out ? ($urandom_range(3, 0) != 0) : a_rdy;
        bus.M_AXIS_B_tready     = rnd_out ? ($urandom_range(3, 0) != 0) : b_rdy;
        #3;
        if (bus.S_AXIS_VAL_tready !== bus.S_AXIS_VEC_tready) align_err++;
        if (bus.S_AXIS_PTR_tvalid && bus.S_AXIS_PTR_tready) void'(ptr_q.pop_front());
        if (bus.S_AXIS_VAL_tvalid && bus.S_AXIS_VAL_tready) begin
            val_acc++;
            void'(val_q.pop_front());
        end
        if (bus.S_AXIS_VEC_tvalid && bus.S_AXIS_VEC_tready) void'(vec_q.pop_front());
        if (bus.M_AXIS_TIMES_tvalid && bus.M_AXIS_TIMES_tready) times_got.push_back(bus.M_AXIS_TIMES_tdata);
        if (bus.M_AXIS_A_tvalid && bus.M_AXIS_A_tready) begin
            a_got.push_back(bus.M_AXIS_A_tdata);
            a_cyc.push_back(cyc);
        end
        if (bus.M_AXIS_B_tvalid && bus.M_AXIS_B_tready) b_got.push_back(bus.M_AXIS_B_tdata);
        if (hv_t && !(bus.M_AXIS_TIMES_tvalid && bus.M_AXIS_TIMES_tdata == hd_t)) stab_err++;
        if (hv_a && !(bus.M_AXIS_A_tvalid && bus.M_AXIS_A_tdata == hd_a)) stab_err++;
        if (hv_b && !(bus.M_AXIS_B_tvalid && bus.M_AXIS_B_tdata == hd_b)) stab_err++;
        hv_t = bus.M_AXIS_TIMES_tvalid && !bus.M_AXIS_TIMES_tready;
        hv_a = bus.M_AXIS_A_tvalid && !bus.M_AXIS_A_tready;
        hv_b = bus.M_AXIS_B_tvalid && !bus.M_AXIS_B_tready;
        hd_t = bus.M_AXIS_TIMES_tdata;
        hd_a = bus.M_AXIS_A_tdata;
        hd_b = bus.M_AXIS_B_tdata;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ptr_q.delete(); val_q.delete(); vec_q.delete();
        times_got.delete(); a_got.delete(); b_got.delete(); a_cyc.delete();
        bus.S_AXIS_PTR_tvalid = 1'b0;
        bus.S_AXIS_VAL_tvalid = 1'b0;
        bus.S_AXIS_VEC_tvalid = 1'b0;
        rnd_in = 1'b0; rnd_out = 1'b0;
        t_rdy = 1'b1; a_rdy = 1'b1; b_rdy = 1'b1;
        cyc = 0; val_acc = 0; stab_err = 0; align_err = 0;
        hv_t = 1'b0; hv_a = 1'b0; hv_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: walk the pointer list row by row with plain arithmetic.
    task automatic build_expect();
        ptr_t        pq[$];
        logic [63:0] vq[$], wq[$];
        logic [31:0] base, len;
        bit          have;
        pq = ptr_q; vq = val_q; wq = vec_q;
        have = 1'b0; base = '0;
        exp_times.delete(); exp_a.delete(); exp_b.delete();
        exp_err = 1'b0;
        foreach (pq[i]) begin
            if (!have) begin
                base = pq[i].p;
                have = !pq[i].last;
            end else begin
                if (pq[i].p < base) begin
                    exp_err = 1'b1;
                    len = 0;
                end else begin
                    len = pq[i].p - base;
                end
                base = pq[i].p;
                if (len == 0) begin
                    exp_times.push_back(32'd1);
                    exp_a.push_back(64'd0);
                    exp_b.push_back(64'd0);
                end else begin
                    exp_times.push_back(len);
                    for (int unsigned k = 0; k < len; k++) begin
                        exp_a.push_back(vq.pop_front());
                        exp_b.push_back(wq.pop_front());
                    end
                end
                if (pq[i].last) have = 1'b0;
            end
        end
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        int n = 0;
        while (!(ptr_q.size() == 0 && times_got.size() >= exp_times.size() &&
                 a_got.size() >= exp_a.size() && b_got.size() >= exp_b.size() && !busy)
               && n < budget) begin
            step();
            n++;
        end
        ok = (n < budget);
    endtask

    task automatic compare(input string tag, input bit ok);
        chk({tag, " finished"}, 64'(ok), 64'd1);
        chk({tag, " times count"}, 64'(times_got.size()), 64'(exp_times.size()));
        for (int i = 0; i < exp_times.size() && i < times_got.size(); i++)
            chk($sformatf("%s times[%0d]", tag, i), 64'(times_got[i]), 64'(exp_times[i]));
        chk({tag, " A count"}, 64'(a_got.size()), 64'(exp_a.size()));
        chk({tag, " B count"}, 64'(b_got.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_a.size() && i < a_got.size(); i++)
            chk($sformatf("%s A[%0d]", tag, i), a_got[i], exp_a[i]);
        for (int i = 0; i < exp_b.size() && i < b_got.size(); i++)
            chk($sformatf("%s B[%0d]", tag, i), b_got[i], exp_b[i]);
        chk({tag, " err_ptr"}, 64'(err_ptr), 64'(exp_err));
        chk({tag, " rows_done"}, 64'(rows_done), 64'(exp_times.size()));
        chk({tag, " busy idle"}, 64'(busy), 64'd0);
        chk({tag, " stable while stalled"}, 64'(stab_err), 64'd0);
        chk({tag, " VAL/VEC ready aligned"}, 64'(align_err), 64'd0);
    endtask

    function automatic logic [31:0] tget(input int i);
        return (i < times_got.size()) ? times_got[i] : 32'hDEAD_BEEF;
    endfunction

    tvec_t       tbl[6];
    logic [31:0] p0arr[3];

    initial begin
        bit ok;
        int a0, v0, pi, vi, n0_a;
        logic [31:0] t0_got[$];
        logic [63:0] a0_first;

        tbl[0] = '{p0: 0,            p1: 3,            p2: 5,            t1: 3, t2: 2, pairs: 5, err: 0};
        tbl[1] = '{p0: 4,            p1: 4,            p2: 6,            t1: 1, t2: 2, pairs: 3, err: 0};
        tbl[2] = '{p0: 10,           p1: 7,            p2: 9,            t1: 1, t2: 2, pairs: 3, err: 1};
        tbl[3] = '{p0: 0,            p1: 0,            p2: 0,            t1: 1, t2: 1, pairs: 2, err: 0};
        tbl[4] = '{p0: 32'hFFFFFFFE, p1: 32'hFFFFFFFF, p2: 32'hFFFFFFFF, t1: 1, t2: 1, pairs: 2, err: 0};
        tbl[5] = '{p0: 100,          p1: 108,          p2: 108,          t1: 8, t2: 1, pairs: 9, err: 0};
        p0arr = '{32'd4, 32'd4, 32'd6};

        bus0.S_AXIS_PTR_tvalid = 1'b0; bus0.S_AXIS_PTR_tdata = '0; bus0.S_AXIS_PTR_tlast = 1'b0;
        bus0.S_AXIS_VAL_tvalid = 1'b0; bus0.S_AXIS_VAL_tdata = '0;
        bus0.S_AXIS_VEC_tvalid = 1'b0; bus0.S_AXIS_VEC_tdata = '0;
        bus0.M_AXIS_A_tready = 1'b1; bus0.M_AXIS_B_tready = 1'b1; bus0.M_AXIS_TIMES_tready = 1'b1;
        bus.S_AXIS_PTR_tdata = '0; bus.S_AXIS_PTR_tlast = 1'b0;
        bus.S_AXIS_VAL_tdata = '0; bus.S_AXIS_VEC_tdata = '0;
        bus.M_AXIS_A_tready = 1'b1; bus.M_AXIS_B_tready = 1'b1; bus.M_AXIS_TIMES_tready = 1'b1;

        // Reset state, observed while reset is held.
        do_reset();
        rst = 1'b1;
        #1;
        chk("reset PTR_tready", 64'(bus.S_AXIS_PTR_tready), 64'd0);
        chk("reset VAL_tready", 64'(bus.S_AXIS_VAL_tready), 64'd0);
        chk("reset TIMES_tvalid", 64'(bus.M_AXIS_TIMES_tvalid), 64'd0);
        chk("reset A_tvalid", 64'(bus.M_AXIS_A_tvalid), 64'd0);
        chk("reset B_tvalid", 64'(bus.M_AXIS_B_tvalid), 64'd0);
        chk("reset A_tdata", bus.M_AXIS_A_tdata, 64'd0);
        chk("reset rows_done", 64'(rows_done), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset err_ptr", 64'(err_ptr), 64'd0);
        @(negedge clk);
        do_reset();
        step(); step();
        chk("idle PTR_tready", 64'(bus.S_AXIS_PTR_tready), 64'd1);

        // Table-driven three-pointer matrices.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            push_ptr(tbl[t].p0, 1'b0);
            push_ptr(tbl[t].p1, 1'b0);
            push_ptr(tbl[t].p2, 1'b1);
            for (int k = 1; k <= 16; k++) begin
                val_q.push_back($realtobits(real'(k)));
                vec_q.push_back($realtobits(2.0));
            end
            build_expect();
            run_until_done(300, ok);
            compare($sformatf("tbl%0d", t), ok);
            chk($sformatf("tbl%0d TIMES row1", t), 64'(tget(0)), 64'(tbl[t].t1));
            chk($sformatf("tbl%0d TIMES row2", t), 64'(tget(1)), 64'(tbl[t].t2));
            chk($sformatf("tbl%0d pair count", t), 64'(a_got.size()), 64'(tbl[t].pairs));
            chk($sformatf("tbl%0d err_ptr", t), 64'(err_ptr), 64'(tbl[t].err));
        end

        // Skewed backpressure: B stalls for 3 cycles while A keeps draining.
        do_reset();
        push_ptr(0, 1'b0); push_ptr(5, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            val_q.push_back($realtobits(real'(k)));
            vec_q.push_back($realtobits(2.0));
        end
        build_expect();
        for (int n = 0; n < 50 && a_got.size() < 2; n++) step();
        a0 = a_got.size(); v0 = val_acc;
        b_rdy = 1'b0;
        step(); step(); step();
        chk("skew A handshakes during B stall", 64'(a_got.size() - a0), 64'd1);
        chk("skew inputs taken during B stall", 64'(val_acc - v0), 64'd0);
        b_rdy = 1'b1;
        run_until_done(200, ok);
        compare("skew", ok);

        // Reset in the middle of a row.
        do_reset();
        push_ptr(0, 1'b0); push_ptr(5, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            val_q.push_back($realtobits(real'(k)));
            vec_q.push_back($realtobits(2.0));
        end
        for (int n = 0; n < 50 && a_got.size() < 2; n++) step();
        chk("midrst reached 2 pairs", 64'(a_got.size()), 64'd2);
        rst = 1'b1;
        #1;
        chk("midrst TIMES_tvalid", 64'(bus.M_AXIS_TIMES_tvalid), 64'd0);
        chk("midrst A_tvalid", 64'(bus.M_AXIS_A_tvalid), 64'd0);
        chk("midrst B_tvalid", 64'(bus.M_AXIS_B_tvalid), 64'd0);
        chk("midrst PTR_tready", 64'(bus.S_AXIS_PTR_tready), 64'd0);
        chk("midrst VAL_tready", 64'(bus.S_AXIS_VAL_tready), 64'd0);
        chk("midrst VEC_tready", 64'(bus.S_AXIS_VEC_tready), 64'd0);
        chk("midrst rows_done", 64'(rows_done), 64'd0);
        @(negedge clk);
        do_reset();
        push_ptr(0, 1'b0); push_ptr(1, 1'b1);
        val_q.push_back($realtobits(7.0));
        vec_q.push_back($realtobits(3.0));
        build_expect();
        run_until_done(100, ok);
        compare("after reset", ok);

        // Throughput: one 64-nnz row, everything always valid/ready.
        do_reset();
        push_ptr(0, 1'b0); push_ptr(64, 1'b1);
        for (int k = 0; k < 64; k++) begin
            val_q.push_back({$urandom, $urandom});
            vec_q.push_back({$urandom, $urandom});
        end
        build_expect();
        run_until_done(300, ok);
        compare("throughput", ok);
        chk("throughput A handshakes", 64'(a_cyc.size()), 64'd64);
        if (a_cyc.size() == 64)
            chk("throughput no bubbles", 64'(a_cyc[63] - a_cyc[0]), 64'd63);

        // Randomized matrices, random valids and readies.
        for (int it = 0; it < 4; it++) begin
            logic [31:0] p;
            int nrows;
            do_reset();
            rnd_in = 1'b1; rnd_out = 1'b1;
            for (int m = 0; m < int'($urandom_range(4, 1)); m++) begin
                nrows = int'($urandom_range(6, 0));
                p = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15, 0)
                                                : 32'($urandom_range(1000, 0));
                push_ptr(p, nrows == 0);
                for (int r = 0; r < nrows; r++) begin
                    if ($urandom_range(9, 0) == 0) p = p - $urandom_range(3, 1);
                    else p = p + $urandom_range(4, 0);
                    push_ptr(p, r == nrows - 1);
                end
            end
            for (int k = 0; k < 200; k++) begin
                val_q.push_back({$urandom, $urandom});
                vec_q.push_back({$urandom, $urandom});
            end
            build_expect();
            run_until_done(4000, ok);
            compare($sformatf("rand%0d", it), ok);
        end

        // PAD_EMPTY=0 instance: ptrs 4,4,6 -> TIMES 0 (no pair), then TIMES 2.
        do_reset();
        pi = 0; vi = 1; n0_a = 0; a0_first = '1;
        for (int n = 0; n < 80; n++) begin
            bus0.S_AXIS_PTR_tvalid = (pi < 3);
            bus0.S_AXIS_PTR_tdata  = (pi < 3) ? p0arr[pi] : '0;
            bus0.S_AXIS_PTR_tlast  = (pi == 2);
            bus0.S_AXIS_VAL_tvalid = 1'b1;
            bus0.S_AXIS_VAL_tdata  = $realtobits(real'(vi));
            bus0.S_AXIS_VEC_tvalid = 1'b1;
            bus0.S_AXIS_VEC_tdata  = $realtobits(2.0);
            #3;
            if (bus0.S_AXIS_PTR_tvalid && bus0.S_AXIS_PTR_tready) pi++;
            if (bus0.S_AXIS_VAL_tready) vi++;
            if (bus0.M_AXIS_TIMES_tvalid) t0_got.push_back(bus0.M_AXIS_TIMES_tdata);
            if (bus0.M_AXIS_A_tvalid) begin
                if (n0_a == 0) a0_first = bus0.M_AXIS_A_tdata;
                n0_a++;
            end
            @(negedge clk);
        end
        bus0.S_AXIS_VAL_tvalid = 1'b0;
        bus0.S_AXIS_VEC_tvalid = 1'b0;
        chk("nopad times count", 64'(t0_got.size()), 64'd2);
        if (t0_got.size() == 2) begin
            chk("nopad TIMES row1", 64'(t0_got[0]), 64'd0);
            chk("nopad TIMES row2", 64'(t0_got[1]), 64'd2);
        end
        chk("nopad pair count", 64'(n0_a), 64'd2);
        chk("nopad first A", a0_first, $realtobits(1.0));
        chk("nopad rows_done", 64'(rows_done0), 64'd2);
        chk("nopad err_ptr", 64'(err_ptr0), 64'd0);
        chk("nopad busy idle", 64'(busy0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spmv_row_dispatcher.md
Name: spmv_row_dispatcher

Overview:
- Producer side of the SpMV dot-product datapath.
- Consumes a CSR row-pointer stream, a nonzero-value stream and a gathered-vector stream.
- Emits, per row, one row-length word (TIMES) followed by exactly that many lock-stepped A/B operand pairs, which is the sequence the vector-dot consumer expects.
- Pads empty rows so every row yields exactly one accumulated result downstream.

Parameters:
- PTR_W, 32, width of row pointers and TIMES.
- DATA_W, 64, width of value/vector operands (IEEE double).
- PAD_EMPTY, 1, 1: an empty row emits TIMES=1 plus one (0.0, 0.0) pair; 0: an empty row emits TIMES=0 and no pair.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- S_AXIS_PTR_tdata  in  PTR_W  row pointer.
- S_AXIS_PTR_tvalid  in  1
- S_AXIS_PTR_tready  out  1
- S_AXIS_PTR_tlast  in  1  marks the final pointer (end pointer) of a matrix.
- S_AXIS_VAL_tdata  in  DATA_W  matrix nonzero value.
- S_AXIS_VAL_tvalid  in  1
- S_AXIS_VAL_tready  out  1
- S_AXIS_VEC_tdata  in  DATA_W  gathered x[col].
- S_AXIS_VEC_tvalid  in  1
- S_AXIS_VEC_tready  out  1
- M_AXIS_A_tdata  out  DATA_W
- M_AXIS_A_tvalid  out  1
- M_AXIS_A_tready  in  1
- M_AXIS_B_tdata  out  DATA_W
- M_AXIS_B_tvalid  out  1
- M_AXIS_B_tready  in  1
- M_AXIS_TIMES_tdata  out  PTR_W  nonzeros in the row.
- M_AXIS_TIMES_tvalid  out  1
- M_AXIS_TIMES_tready  in  1
- rows_done  out  32  count of TIMES handshakes; wraps 0xFFFFFFFF -> 0.
- busy  out  1  high whenever state != IDLE or any output valid is high.
- err_ptr  out  1  sticky; set when a pointer is smaller than its predecessor.

Behaviour:
- Reset (async, rst=1): state=IDLE. All m_*_tvalid=0, all s_*_tready=0, output data=0, rows_done=0, err_ptr=0, busy=0. Any partial row is discarded. Operation resumes on the first clk edge after rst deasserts.
- FSM states:
  - IDLE: PTR_tready=1. Accepted pointer -> base; -> WAIT_PTR. If tlast is set on this first pointer, it is a zero-row matrix; stay in IDLE.
  - WAIT_PTR: PTR_tready=1. Accepted pointer p gives len = p - base (unsigned PTR_W); base <= p. If p < base: set err_ptr and force len=0. Load the TIMES register with len (or 1 if len=0 and PAD_EMPTY=1). Latch last_row = tlast. -> TIMES.
  - TIMES: M_AXIS_TIMES_tvalid=1 with data stable until handshake. On handshake rows_done++ and remaining <= len. Next state: STREAM if len>0; PAD if len=0 and PAD_EMPTY=1; otherwise (IDLE if last_row, else WAIT_PTR).
  - STREAM: VAL_tready = VEC_tready = (remaining!=0) & slot_free & VAL_tvalid & VEC_tvalid. Both inputs are accepted in the same cycle only; neither is ever accepted alone. Each accepted pair loads the output pair register and decrements remaining. When remaining reaches 0 and the slot drains: -> IDLE if last_row, else WAIT_PTR.
  - PAD: load pair (0, 0) once, with no input consumed; after it drains, same exit rule as STREAM.
- Output pair register:
  - Holds A and B data with independent pending flags a_pend and b_pend. Each flag clears on its own handshake.
  - slot_free = (!a_pend | A_tready) & (!b_pend | B_tready).
  - A new pair load sets both flags. No new pair loads while either flag is still set, so A and B order never skews.
- Latency and throughput:
  - Pointer accepted at edge N -> TIMES_tvalid at N+1.
  - Pair accepted at N -> A/B valid at N+1.
  - Sustains 1 pair/clk with both readies high.
- Output valids never depend combinationally on the corresponding ready. Data stays stable while valid is high and not accepted.
- PTR_tready=0 in the TIMES, STREAM and PAD states, so only one row is in flight.
- Length arithmetic is modulo 2^PTR_W. Only a decreasing pointer is flagged; no other overflow detection.
- After a tlast row, the next pointer is treated as a new matrix base.

Test Plan:
- Basic rows: ptrs 0,3,5(tlast); VAL 1.0..5.0; VEC all 2.0; all ready -> TIMES 3 then 2; A=1.0..5.0 in order; B=2.0 x5; rows_done=2; IDLE, busy=0.
- Empty row: ptrs 4,4,6(tlast) -> PAD_EMPTY=1: TIMES 1, pair (0x0, 0x0) with no VAL/VEC consumed, then TIMES 2 and two pairs. PAD_EMPTY=0: TIMES 0, no pair, then TIMES 2.
- Skewed backpressure: A_tready=1, B_tready=0 for 3 cycles mid-row -> A accepted once; no new pair loaded; VAL/VEC tready=0; B completes later; sequence and pair alignment intact.
- Bad pointer: ptrs 10,7,9 -> err_ptr=1 (sticky); row 1 padded as empty; row 2 TIMES=2.
- Reset mid-row: assert rst after 2 of 5 pairs -> all valids/readies 0 immediately; rows_done=0. Fresh matrix ptrs 0,1(tlast) then yields TIMES 1 and one pair.
- Throughput: 64-nnz row with inputs always valid and outputs always ready -> 64 A/B handshakes in 64 consecutive cycles, no bubbles.
